pu_scheduler: RTL and testbench
===============================

Name: pu_scheduler

Overview:
- Front-end controller that shares one Processing_Unit (8-bit ALU, opcode-driven, registered result) between two independent requesters.
- Arbitrates round-robin, latches and holds operands/opcode stable at the PU for the programmed latency, captures result/overflow, and returns a tagged response over a valid/ready channel.
- Sits between the two command sources and the PU; the PU's clock and reset nets are shared with this block.

Parameters:
- PU_LATENCY, 1: clock cycles from PU inputs becoming stable to result_data/overflow being valid; legal range 1..15.
- DATA_W, 8: operand/result width; must match the PU.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_opcode  in  8  PU operation code
- req0_a  in  DATA_W  operand a
- req0_b  in  DATA_W  operand b
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b: same as requester 0
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester the response belongs to
- rsp_result  out  DATA_W  captured PU result_data
- rsp_overflow  out  1  captured PU overflow
- rsp_error  out  1  opcode rejected (only with optional feature, else 0)
- pu_operation  out  8  to PU operation
- pu_data_a  out  DATA_W  to PU data_a
- pu_data_b  out  DATA_W  to PU data_b
- pu_result_data  in  DATA_W  from PU result_data
- pu_overflow  in  1  from PU overflow

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; wait counter 0; last_grant=1, so req0 wins the first tie.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant is combinational from the valid inputs. Single valid requester gets the grant. Both valid: the requester other than last_grant gets it.
  - Only the granted reqN_ready is high; neither is high outside IDLE.
  - On a valid&ready edge: latch opcode/a/b into pu_* registers, record the id, update last_grant, load the counter with PU_LATENCY, and go to WAIT.
- WAIT:
  - pu_* held constant; counter decrements each cycle.
  - On the edge where the counter equals 1: capture pu_result_data and pu_overflow into the rsp_* registers, set rsp_valid, go to RESP.
- RESP:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&rsp_ready: clear rsp_valid and go to IDLE.
  - rsp_ready is ignored when rsp_valid=0.
- Timing for an accept at edge T:
  - WAIT occupies cycles T+1..T+PU_LATENCY.
  - rsp_valid is high from cycle T+PU_LATENCY+1.
  - With rsp_ready=1, a new accept is possible at edge T+PU_LATENCY+2.
  - Peak throughput: one operation per PU_LATENCY+2 cycles.
- pu_* keep the last issued values between operations; they are never driven with unlatched requester inputs.
- Requester inputs are sampled only at the accept edge. Later changes have no effect.
- A requester that drops valid before ready is legal and is simply not served.
- Reset mid-WAIT or mid-RESP: the operation and response are discarded, nothing is replayed, and the FSM restarts from IDLE.
- Arithmetic: the block never modifies data. Result and overflow semantics belong to the PU (ADD 8'b00101011, SUB 8'b00101101, MUL 8'b00101010, DIV 8'b00101111, AND 8'b00100110, OR 8'b01111100).

Optional Feature:
- Macro: PU_SCHED_OPCODE_CHECK_EN.
- When defined:
  - In IDLE, an accepted opcode outside the six legal codes skips WAIT.
  - Next cycle: state RESP with rsp_error=1, rsp_result=0, rsp_overflow=0.
  - pu_* are not updated.
- When undefined:
  - Every opcode is forwarded to the PU.
  - rsp_error is tied to 0.

Decomposition:
- Package pu_sched_pkg: opcode localparams (OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR), state enum typedef, requester-id typedef, legal-opcode function.
- One sub-module, pu_rr_arbiter: 2-way round-robin grant from valid inputs and a last_grant register, with an update-on-accept input.

Test Plan:
- Single op: req0 ADD a=120 b=110, rsp_ready=1 -> rsp_valid at accept+PU_LATENCY+1, rsp_id=0, rsp_result=230, rsp_overflow=0.
- Overflow: req1 ADD 120+240 and MUL 10*30 -> rsp_overflow=1, rsp_id=1, result equal to PU output.
- Tie after reset: both valid with req0 SUB 125-110 and req1 DIV 15/5 -> req0 served first (result 15), then req1 (result 3). A second tie is served req1-then-req0 only if req0 won the last tie, i.e. strict alternation.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req0_ready=req1_ready=0; release -> one handshake, then IDLE.
- Reset mid-WAIT (PU_LATENCY=3, reset low in second WAIT cycle) -> all outputs 0 immediately, no response emitted, next tie granted to req0.
- Opcode 8'hFF on req0: with PU_SCHED_OPCODE_CHECK_EN -> rsp_error=1 one cycle after accept, pu_operation unchanged. Without the macro -> forwarded and rsp_error=0.

Source files
------------

// File: rtl/pu_sched_pkg.sv
// pu_sched_pkg
//   Shared definitions for the PU scheduler: the six PU opcodes the
//   scheduler knows about, the scheduler FSM state type, the requester id
//   type and a helper that tells whether an opcode is one the PU implements.
//   No ports (package).
package pu_sched_pkg;

  localparam logic [7:0] OP_ADD = 8'b00101011;
  localparam logic [7:0] OP_SUB = 8'b00101101;
  localparam logic [7:0] OP_MUL = 8'b00101010;
  localparam logic [7:0] OP_DIV = 8'b00101111;
  localparam logic [7:0] OP_AND = 8'b00100110;
  localparam logic [7:0] OP_OR  = 8'b01111100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  function automatic logic op_is_legal(input logic [7:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR: op_is_legal = 1'b1;
      default:                                       op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pu_rr_arbiter.sv
// pu_rr_arbiter
//   Two-way round-robin arbiter. The grant is purely combinational from the
//   valid inputs; when both are valid the requester that did not win last
//   time is chosen. The last winner is remembered only when the caller
//   signals that the grant was actually taken (accept).
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset (last winner := REQ1)
//   valid0/1  in   requester valids
//   accept    in   the current grant was consumed this cycle
//   grant0/1  out  one-hot grant (both low when nothing is valid)
//   grant_id  out  id of the granted requester
module pu_rr_arbiter
  import pu_sched_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    valid0,
  input  logic    valid1,
  input  logic    accept,
  output logic    grant0,
  output logic    grant1,
  output req_id_t grant_id
);

  req_id_t last_grant;

  always_comb begin
    grant_id = REQ0;
    if (valid0 && valid1) begin
      grant_id = (last_grant == REQ0) ? REQ1 : REQ0;
    end else if (valid1) begin
      grant_id = REQ1;
    end
  end

  assign grant0 = valid0 && (grant_id == REQ0);
  assign grant1 = valid1 && (grant_id == REQ1);

  // Resetting to REQ1 makes REQ0 the winner of the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= REQ1;
    end else if (accept) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/pu_scheduler.sv
// pu_scheduler
//   Shares one Processing Unit between two requesters. A round-robin winner
//   is accepted in IDLE, its opcode/operands are latched onto the PU inputs
//   and held for PU_LATENCY cycles, then the PU result/overflow is captured
//   and returned as a tagged response on a valid/ready channel.
//
//   Optional build macro PU_SCHED_OPCODE_CHECK_EN: when defined, an accepted
//   opcode the PU does not implement bypasses the PU and is answered
//   directly with rsp_error=1 (result/overflow 0, PU inputs untouched).
//   When undefined every opcode goes to the PU and rsp_error is tied low.
//
// Ports:
//   clock, reset                   clock / async active-low reset
//   req{0,1}_valid/ready           command handshake per requester
//   req{0,1}_opcode/_a/_b          command payload, sampled at accept only
//   rsp_valid/ready                response handshake
//   rsp_id/result/overflow/error   response payload
//   pu_operation/pu_data_a/b       registered drive to the PU
//   pu_result_data/pu_overflow     PU outputs
//
// state | meaning
// IDLE  | arbitrating; the granted requester sees ready
// WAIT  | PU inputs held, latency counter running down
// RESP  | response presented, waiting for rsp_ready
module pu_scheduler
  import pu_sched_pkg::*;
#(
  parameter int PU_LATENCY = 1,
  parameter int DATA_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [7:0]        req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [7:0]        req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_overflow,
  output logic              rsp_error,
  output logic [7:0]        pu_operation,
  output logic [DATA_W-1:0] pu_data_a,
  output logic [DATA_W-1:0] pu_data_b,
  input  logic [DATA_W-1:0] pu_result_data,
  input  logic              pu_overflow
);

  localparam logic [3:0] LAT = 4'(PU_LATENCY);

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt;
  req_id_t           cur_id;
  req_id_t           grant_id;
  logic              grant0, grant1;
  logic              accept;
  logic              op_bad;
  logic [7:0]        sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;

  pu_rr_arbiter u_arb (
    .clock    (clock),
    .reset    (reset),
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .accept   (accept),
    .grant0   (grant0),
    .grant1   (grant1),
    .grant_id (grant_id)
  );

  // Ready is qualified by reset so that every output reads 0 the moment
  // reset is asserted, even though the arbiter grant is combinational.
  assign req0_ready = reset && (state == IDLE) && grant0;
  assign req1_ready = reset && (state == IDLE) && grant1;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign sel_op = (grant_id == REQ1) ? req1_opcode : req0_opcode;
  assign sel_a  = (grant_id == REQ1) ? req1_a      : req0_a;
  assign sel_b  = (grant_id == REQ1) ? req1_b      : req0_b;

`ifdef PU_SCHED_OPCODE_CHECK_EN
  assign op_bad = !op_is_legal(sel_op);
`else
  assign op_bad = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = op_bad ? RESP : WAIT;
      WAIT: if (wait_cnt == 4'd1) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt     <= 4'd0;
      cur_id       <= REQ0;
      pu_operation <= 8'd0;
      pu_data_a    <= '0;
      pu_data_b    <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur_id <= grant_id;
            if (op_bad) begin
              // Rejected opcode: answer immediately, PU inputs keep their
              // previously issued values.
              rsp_valid    <= 1'b1;
              rsp_id       <= grant_id;
              rsp_result   <= '0;
              rsp_overflow <= 1'b0;
            end else begin
              pu_operation <= sel_op;
              pu_data_a    <= sel_a;
              pu_data_b    <= sel_b;
              wait_cnt     <= LAT;
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            rsp_valid    <= 1'b1;
            rsp_id       <= cur_id;
            rsp_result   <= pu_result_data;
            rsp_overflow <= pu_overflow;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef PU_SCHED_OPCODE_CHECK_EN
  logic rsp_error_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_error_q <= 1'b0;
    end else if (state == IDLE && accept) begin
      rsp_error_q <= op_bad;
    end
  end

  assign rsp_error = rsp_error_q;
`else
  assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_pu_scheduler.sv
// tb_pu_scheduler
//   Self-checking bench for pu_scheduler (PU_LATENCY=3). A behavioural PU
//   model answers combinationally from the registered PU inputs. Expected
//   grants come from a "who was served last" variable, expected results
//   from plain arithmetic on the opcode. A constant table covers the
//   directed cases; hand sequences cover backpressure, dropped requests,
//   opcode 8'hFF and reset during WAIT; a random phase finishes the run.
module tb_pu_scheduler;

  localparam int LAT = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_opcode = 8'd0, req0_a = 8'd0, req0_b = 8'd0;
  logic [7:0] req1_opcode = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_overflow, rsp_error;
  logic [7:0] rsp_result;
  logic [7:0] pu_operation, pu_data_a, pu_data_b, pu_result_data;
  logic       pu_overflow;

  int tests = 0;
  int fails = 0;

  logic       last_served = 1'b1;
  logic [7:0] exp_pu_op = 8'd0, exp_pu_a = 8'd0, exp_pu_b = 8'd0;

  always #5 clock = ~clock;

  pu_scheduler #(.PU_LATENCY(LAT), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_error(rsp_error),
    .pu_operation(pu_operation), .pu_data_a(pu_data_a), .pu_data_b(pu_data_b),
    .pu_result_data(pu_result_data), .pu_overflow(pu_overflow)
  );

  // Behavioural PU: {overflow, result}
  function automatic logic [8:0] pu_func(input logic [7:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [15:0] w;
    w = 16'd0;
    case (op)
      8'h2B: begin w = 16'(a) + 16'(b); return {w[8], w[7:0]}; end
      8'h2D: return {a < b, 8'(a - b)};
      8'h2A: begin w = 16'(a) * 16'(b); return {|w[15:8], w[7:0]}; end
      8'h2F: return (b == 8'd0) ? 9'h100 : {1'b0, 8'(a / b)};
      8'h26: return {1'b0, a & b};
      8'h7C: return {1'b0, a | b};
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic op_legal(input logic [7:0] op);
    return op == 8'h2B || op == 8'h2D || op == 8'h2A ||
           op == 8'h2F || op == 8'h26 || op == 8'h7C;
  endfunction

  assign {pu_overflow, pu_result_data} = pu_func(pu_operation, pu_data_a, pu_data_b);

  typedef struct {
    logic       v0, v1;
    logic [7:0] op0, a0, b0, op1, a1, b1;
    logic       exp_id;
    logic [7:0] exp_res;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input int stall, input string tag);
    int n;
    int exp_lat;
    logic [7:0] op_s, a_s, b_s, e_res;
    logic e_ovf, e_err;
    @(negedge clock);
    req0_valid = v.v0; req0_opcode = v.op0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_opcode = v.op1; req1_a = v.a1; req1_b = v.b1;
    rsp_ready  = (stall == 0);
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 20) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL %s grant_timeout: no ready within 20 cycles", tag);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    check({tag, " grant"}, 64'(req1_ready), 64'(v.exp_id));
    check({tag, " ready_onehot"}, 64'(req0_ready & req1_ready), 64'd0);
    op_s = v.exp_id ? v.op1 : v.op0;
    a_s  = v.exp_id ? v.a1  : v.a0;
    b_s  = v.exp_id ? v.b1  : v.b0;
    @(posedge clock); #1;
    // Scramble the payload after the accept edge; it must not matter.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_opcode = 8'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
    req1_opcode = 8'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
    e_res = v.exp_res; e_ovf = v.exp_ovf; e_err = 1'b0; exp_lat = LAT + 1;
`ifdef PU_SCHED_OPCODE_CHECK_EN
    if (!op_legal(op_s)) begin
      e_err = 1'b1; exp_lat = 1; e_res = 8'd0; e_ovf = 1'b0;
    end else begin
      exp_pu_op = op_s; exp_pu_a = a_s; exp_pu_b = b_s;
    end
`else
    exp_pu_op = op_s; exp_pu_a = a_s; exp_pu_b = b_s;
`endif
    n = 0;
    do begin
      @(negedge clock); n++;
    end while (!rsp_valid && n < 40);
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " rsp"}, {rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_error},
          {1'b1, v.exp_id, e_res, e_ovf, e_err});
    check({tag, " pu_inputs"}, {pu_operation, pu_data_a, pu_data_b},
          {exp_pu_op, exp_pu_a, exp_pu_b});
    last_served = v.exp_id;
    for (int k = 0; k < stall; k++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check({tag, " stall_ready"}, {req0_ready, req1_ready}, 64'd0);
      check({tag, " stall_hold"}, {rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_error},
            {1'b1, v.exp_id, e_res, e_ovf, e_err});
      @(negedge clock);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    @(negedge clock);
    check({tag, " rsp_cleared"}, 64'(rsp_valid), 64'd0);
  endtask

  function automatic logic [7:0] pick_op();
    logic [7:0] ops[6];
    int idx;
    ops = '{8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h26, 8'h7C};
    idx = $urandom_range(0, 6);
    return (idx == 6) ? 8'($urandom) : ops[idx];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    vec_t r;
    logic [8:0] pr;

    //        v0 v1  op0    a0     b0     op1    a1     b1    id   res     ovf
    tbl[0] = '{1, 1, 8'h2D, 8'd125, 8'd110, 8'h2F, 8'd15, 8'd5,  1'b0, 8'd15,  1'b0};
    tbl[1] = '{1, 1, 8'h2D, 8'd125, 8'd110, 8'h2F, 8'd15, 8'd5,  1'b1, 8'd3,   1'b0};
    tbl[2] = '{1, 1, 8'h2D, 8'd125, 8'd110, 8'h2F, 8'd15, 8'd5,  1'b0, 8'd15,  1'b0};
    tbl[3] = '{1, 0, 8'h2B, 8'd120, 8'd110, 8'h00, 8'd0,  8'd0,  1'b0, 8'd230, 1'b0};
    tbl[4] = '{0, 1, 8'h00, 8'd0,   8'd0,   8'h2B, 8'd120, 8'd240, 1'b1, 8'd104, 1'b1};
    tbl[5] = '{0, 1, 8'h00, 8'd0,   8'd0,   8'h2A, 8'd10, 8'd30, 1'b1, 8'd44,  1'b1};
    tbl[6] = '{1, 1, 8'h26, 8'hF0,  8'h3C,  8'h7C, 8'h0F, 8'h30, 1'b0, 8'h30,  1'b0};
    tbl[7] = '{1, 1, 8'h26, 8'hF0,  8'h3C,  8'h7C, 8'h0F, 8'h30, 1'b1, 8'h3F,  1'b0};
    tbl[8] = '{1, 0, 8'h2D, 8'd5,   8'd10,  8'h00, 8'd0,  8'd0,  1'b0, 8'd251, 1'b1};

    // Reset state, with both requesters asking.
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #12;
    check("reset_outputs",
          {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow,
           rsp_error, pu_operation, pu_data_a, pu_data_b}, 64'd0);
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(tbl[i], i % 3, $sformatf("tbl%0d", i));

    // Long backpressure.
    r = '{1, 0, 8'h2B, 8'd1, 8'd2, 8'h00, 8'd0, 8'd0, 1'b0, 8'd3, 1'b0};
    run_txn(r, 5, "backpressure");

    // A requester that withdraws before the edge is not served.
    @(negedge clock);
    req1_valid = 1'b1; req1_opcode = 8'h2B; req1_a = 8'd9; req1_b = 8'd9;
    #1;
    check("drop_ready_idle", {req0_ready, req1_ready}, 64'b01);
    req1_valid = 1'b0;
    seen = 1'b0;
    repeat (LAT + 3) begin
      @(negedge clock);
      seen |= rsp_valid;
    end
    check("drop_not_served", 64'(seen), 64'd0);

    // Unknown opcode.
    pr = pu_func(8'hFF, 8'd7, 8'd9);
    r = '{1, 0, 8'hFF, 8'd7, 8'd9, 8'h00, 8'd0, 8'd0, 1'b0, pr[7:0], pr[8]};
    run_txn(r, 1, "op_ff");

    // Reset in the second WAIT cycle after a req0 accept.
    @(negedge clock);
    req0_valid = 1'b1; req0_opcode = 8'h2B; req0_a = 8'd3; req0_b = 8'd4;
    #1;
    check("prereset_ready", {req0_ready, req1_ready}, 64'b10);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    @(posedge clock); #2;
    reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("midwait_reset_outputs",
          {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow,
           rsp_error, pu_operation, pu_data_a, pu_data_b}, 64'd0);
    exp_pu_op = 8'd0; exp_pu_a = 8'd0; exp_pu_b = 8'd0;
    last_served = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    seen = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clock);
      seen |= rsp_valid;
    end
    check("midwait_no_replay", 64'(seen), 64'd0);
    run_txn(tbl[0], 0, "post_reset_tie");

    // Random phase against the behavioural model.
    for (int i = 0; i < 40; i++) begin
      r.v0 = 1'($urandom_range(0, 1));
      r.v1 = 1'($urandom_range(0, 1));
      if (!r.v0 && !r.v1) r.v0 = 1'b1;
      r.op0 = pick_op(); r.a0 = 8'($urandom); r.b0 = 8'($urandom);
      r.op1 = pick_op(); r.a1 = 8'($urandom); r.b1 = 8'($urandom);
      r.exp_id = (r.v0 && r.v1) ? ~last_served : r.v1;
      pr = r.exp_id ? pu_func(r.op1, r.a1, r.b1) : pu_func(r.op0, r.a0, r.b0);
      r.exp_res = pr[7:0];
      r.exp_ovf = pr[8];
      run_txn(r, $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
